// File: rtl/minisys_io_pkg.sv
// minisys_io_pkg: shared register offsets, MODE/STATUS bit positions and default width for Minisys I/O peripherals
package minisys_io_pkg;
   localparam int DEF_CNT_W = 16;
   typedef enum logic [1:0] {
      REG_MODE0 = 2'b00,
      REG_MODE1 = 2'b01,
      REG_CNT0  = 2'b10,
      REG_CNT1  = 2'b11
   } reg_e;
   localparam int MODE_SRC_BIT = 0;
   localparam int MODE_RPT_BIT = 1;
   localparam int ST_DONE_BIT  = 0;
   localparam int ST_SRC_BIT   = 1;
   localparam int ST_RPT_BIT   = 2;
   localparam int ST_RUN_BIT   = 15;
endpackage

// File: rtl/timer16_if.sv
// timer16_if: Minisys I/O bus slice seen by the timer (decoder side is master, timer is slave)
interface timer16_if import minisys_io_pkg::*; #(
   parameter int CNT_W = DEF_CNT_W
);
   logic             timerctrl;
   logic             iowrite;
   logic             ioread;
   logic [2:0]       address;
   logic [CNT_W-1:0] wdata;
   logic [CNT_W-1:0] rdata;
   modport master (output timerctrl, iowrite, ioread, address, wdata, input rdata);
   modport slave  (input timerctrl, iowrite, ioread, address, wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// timer_channel: one down-counting channel with input synchronizer, edge detect, auto-reload, sticky done and terminal pulse
module timer_channel import minisys_io_pkg::*; #(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_in,
   input  logic             mode_we,
   input  logic             init_we,
   input  logic             stat_re,
   input  logic [CNT_W-1:0] wdata,
   output logic [CNT_W-1:0] status,
   output logic [CNT_W-1:0] count,
   output logic             pulse
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev, src, rpt, run, done, tick, term;
   logic [CNT_W-1:0]       init;
   // bring the external source into the clk domain and keep its previous value for rising-edge detection
   always_ff @(posedge clk or posedge rst)
      if (rst) {sync, prev} <= '0;
      else {sync, prev} <= {sync[SYNC_STAGES-2:0], cnt_in, sync[SYNC_STAGES-1]};
   // a tick is every cycle in timer mode or one synchronized rising edge in counter mode; an INIT write pre-empts terminal count
   always_comb begin
      tick = src ? sync[SYNC_STAGES-1] & ~prev : 1'b1;
      term = run & tick & (count == CNT_W'(1)) & ~init_we;
   end
   // mode, reload value, counter, run/done flags and the registered terminal pulse
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {src, rpt, run, done, pulse} <= '0;
         init  <= '0;
         count <= '0;
      end else begin
         pulse <= term;
         if (mode_we) {rpt, src} <= {wdata[MODE_RPT_BIT], wdata[MODE_SRC_BIT]};
         if (init_we) begin
            init  <= wdata;
            count <= wdata;
            run   <= |wdata;
         end else if (run & tick) begin
            count <= term ? (rpt ? init : '0) : count - CNT_W'(1);
            if (term) run <= rpt;
         end
         done <= term | (done & ~stat_re & ~(init_we & |wdata));
      end
   // STATUS word: only the defined flag bits are populated
   always_comb begin
      status              = '0;
      status[ST_RUN_BIT]  = run;
      status[ST_RPT_BIT]  = rpt;
      status[ST_SRC_BIT]  = src;
      status[ST_DONE_BIT] = done;
   end
endmodule

// File: rtl/timer16.sv
// timer16: two-channel 16-bit Minisys timer/counter; address decode and read mux. Channel 1 exists only when TIMER_CH1_EN is defined.
module timer16 import minisys_io_pkg::*; #(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   timer16_if.slave   bus,
   input  logic       cnt_in0,
   input  logic       cnt_in1,
   output logic       pulse_out0,
   output logic       pulse_out1
);
   logic             we, re, unused_a0;
   reg_e             sel;
   logic [CNT_W-1:0] st0, st1, cnt0, cnt1;
   // qualify strobes with chip select; address bit 0 does not participate in decode
   always_comb begin
      we  = bus.timerctrl & bus.iowrite;
      re  = bus.timerctrl & bus.ioread;
      sel = reg_e'(bus.address[2:1]);
   end
   assign unused_a0 = bus.address[0];
   timer_channel #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_ch0 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in0),
      .mode_we(we & sel == REG_MODE0), .init_we(we & sel == REG_CNT0), .stat_re(re & sel == REG_MODE0),
      .wdata(bus.wdata), .status(st0), .count(cnt0), .pulse(pulse_out0)
   );
`ifdef TIMER_CH1_EN
   timer_channel #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_ch1 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in1),
      .mode_we(we & sel == REG_MODE1), .init_we(we & sel == REG_CNT1), .stat_re(re & sel == REG_MODE1),
      .wdata(bus.wdata), .status(st1), .count(cnt1), .pulse(pulse_out1)
   );
`else
   logic unused_cnt_in1;
   assign unused_cnt_in1 = cnt_in1;
   assign st1        = '0;
   assign cnt1       = '0;
   assign pulse_out1 = 1'b0;
`endif
   // read mux; anything not a qualified read returns zero
   always_comb
      bus.rdata = !re ? '0 : sel == REG_MODE0 ? st0 : sel == REG_MODE1 ? st1 : sel == REG_CNT0 ? cnt0 : cnt1;
endmodule

// File: tb/tb_timer16.sv
// tb_timer16: randomized scoreboard bench for timer16 against a behavioural per-step reference model
module tb_timer16;
   import minisys_io_pkg::*;
   localparam int SYNC = 2;
`ifdef TIMER_CH1_EN
   localparam bit CH1 = 1'b1;
`else
   localparam bit CH1 = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, cnt_in0 = 1'b0, cnt_in1 = 1'b0;
   logic pulse_out0, pulse_out1;
   timer16_if #(.CNT_W(16)) bus();
   timer16 #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .bus(bus), .cnt_in0(cnt_in0), .cnt_in1(cnt_in1),
      .pulse_out0(pulse_out0), .pulse_out1(pulse_out1)
   );
   always #5 clk = ~clk;
   int          nvec = 0, nfail = 0, k = 0;
   logic [15:0] rq[$];
   logic [1:0]  pq[$];
   int          m_init[2], m_cnt[2], due[2], hold[2];
   bit          m_src[2], m_rpt[2], m_run[2], m_done[2], cprev[2], cin[2], cin_en[2], cin_fix;
   function automatic logic [15:0] status_of(input int c);
      return {m_run[c], 12'b0, m_rpt[c], m_src[c], m_done[c]};
   endfunction
   // reference model: expected read is the state before this edge; pulses are what this edge produces
   task automatic model_step(input bit rs, t, w, r, input logic [2:0] a, input logic [15:0] d);
      logic [1:0] p;
      int c;
      p = 2'b00;
      c = int'(a[1]);
      if (r) rq.push_back((rs || !t || (c == 1 && !CH1)) ? 16'h0 : (a[2] ? 16'(m_cnt[c]) : status_of(c)));
      for (int i = 0; i < 2; i++) begin
         bit tick, iw, mw, sr;
         if (rs || (i == 1 && !CH1)) begin
            m_init[i] = 0; m_cnt[i] = 0; m_src[i] = 0; m_rpt[i] = 0;
            m_run[i] = 0; m_done[i] = 0; due[i] = -1; cprev[i] = 0;
            continue;
         end
         tick = m_src[i] ? (due[i] == k) : 1'b1;
         if (cin[i] && !cprev[i]) due[i] = k + SYNC;
         cprev[i] = cin[i];
         iw = t && w && a[2] && c == i;
         mw = t && w && !a[2] && c == i;
         sr = t && r && !a[2] && c == i;
         if (sr) m_done[i] = 0;
         if (iw) begin
            m_init[i] = int'(d);
            m_cnt[i]  = int'(d);
            m_run[i]  = (d != 16'h0);
            if (d != 16'h0) m_done[i] = 0;
         end else if (m_run[i] && tick) begin
            if (m_cnt[i] == 1) begin
               p[i]      = 1'b1;
               m_done[i] = 1;
               m_cnt[i]  = m_rpt[i] ? m_init[i] : 0;
               m_run[i]  = m_rpt[i];
            end else m_cnt[i]--;
         end
         if (mw) begin
            m_src[i] = d[0];
            m_rpt[i] = d[1];
         end
      end
      pq.push_back(p);
      k++;
   endtask
   // one bus step: drive at the falling edge, generate external count waveforms, and predict
   task automatic cyc(input bit t, w, r, input logic [2:0] a, input logic [15:0] d, input bit rs);
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         if (rs || !cin_en[i]) begin
            cin[i]  = 1'b0;
            hold[i] = 0;
         end else if (hold[i] == 0) begin
            cin[i]  = !cin[i];
            hold[i] = cin_fix ? 2 : int'($urandom_range(1, 4));
         end else hold[i]--;
      rst           = rs;
      cnt_in0       = cin[0];
      cnt_in1       = cin[1];
      bus.timerctrl = t;
      bus.iowrite   = w;
      bus.ioread    = r;
      bus.address   = a;
      bus.wdata     = d;
      model_step(rs, t, w, r, a, d);
   endtask
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cyc(1'b1, 1'b1, 1'b0, a, d, 1'b0);
   endtask
   task automatic rd(input logic [2:0] a);
      cyc(1'b1, 1'b0, 1'b1, a, 16'h0, 1'b0);
   endtask
   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
   endtask
   task automatic reset_for(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
   endtask
   task automatic read_all();
      rd(3'b000); rd(3'b010); rd(3'b100); rd(3'b110);
   endtask
   // pulse monitor: after every edge the outputs must equal the model's prediction for that edge
   initial forever begin
      logic [1:0] e;
      @(posedge clk);
      #1;
      if (pq.size() != 0) begin
         e = pq.pop_front();
         nvec++;
         if ({pulse_out1, pulse_out0} !== e) begin
            nfail++;
            $display("FAIL pulse @%0t: got %b expected %b", $time, {pulse_out1, pulse_out0}, e);
         end
      end
   end
   // read monitor: whenever a read strobe is on the bus, rdata must equal the next queued expectation
   initial forever begin
      logic [15:0] e;
      @(negedge clk);
      #2;
      if (bus.ioread === 1'b1) begin
         nvec++;
         if (rq.size() == 0) begin
            nfail++;
            $display("FAIL rdata @%0t: got %h expected nothing queued", $time, bus.rdata);
         end else begin
            e = rq.pop_front();
            if (bus.rdata !== e) begin
               nfail++;
               $display("FAIL rdata @%0t addr %b: got %h expected %h", $time, bus.address, bus.rdata, e);
            end
         end
      end
   end
   initial begin
      bus.timerctrl = 1'b0; bus.iowrite = 1'b0; bus.ioread = 1'b0; bus.address = 3'd0; bus.wdata = 16'h0;
      cin_fix = 1'b0; cin_en[0] = 1'b0; cin_en[1] = 1'b0;
      reset_for(2);
      read_all();
      wr(3'b000, 16'h0000); wr(3'b100, 16'd5);
      idle(6);
      rd(3'b000); rd(3'b000);
      wr(3'b010, 16'h0002); wr(3'b110, 16'd3);
      for (int i = 0; i < 30; i++) rd((i % 5 == 4) ? 3'b010 : 3'b110);
      wr(3'b100, 16'd9);
      idle(4);
      reset_for(1);
      read_all();
      idle(3);
      wr(3'b000, 16'h0001); wr(3'b100, 16'd4);
      cin_fix = 1'b1; cin_en[0] = 1'b1;
      idle(21);
      cin_en[0] = 1'b0;
      idle(8);
      rd(3'b000); rd(3'b100);
      wr(3'b100, 16'd4);
      idle(12);
      rd(3'b100); rd(3'b000);
      cin_fix = 1'b0;
      wr(3'b000, 16'h0000); wr(3'b100, 16'd3);
      idle(2);
      rd(3'b000); rd(3'b000); rd(3'b000);
      wr(3'b100, 16'd3);
      idle(2);
      wr(3'b100, 16'd9);
      idle(3);
      rd(3'b100); rd(3'b000);
      wr(3'b100, 16'd0);
      idle(3);
      rd(3'b100); rd(3'b000);
      wr(3'b000, 16'h0002); wr(3'b100, 16'd1);
      idle(5);
      rd(3'b100);
      wr(3'b100, 16'd0);
      wr(3'b110, 16'd7);
      rd(3'b110); rd(3'b010);
      cyc(1'b0, 1'b1, 1'b0, 3'b100, 16'd2, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 3'b100, 16'h0, 1'b0);
      rd(3'b100);
      for (int n = 0; n < 2500; n++) begin
         int r;
         logic [2:0] a;
         logic [15:0] d;
         bit t;
         r = int'($urandom_range(0, 99));
         a = 3'($urandom);
         t = ($urandom_range(0, 9) != 0);
         d = 16'($urandom_range(0, 8));
         if (n % 200 == 0) begin
            cin_en[0] = 1'($urandom);
            cin_en[1] = 1'($urandom);
         end
         if (r < 45) idle(1);
         else if (r < 70) cyc(t, 1'b0, 1'b1, a, 16'h0, 1'b0);
         else if (r < 80) cyc(t, 1'b1, 1'b0, {1'b0, a[1:0]}, 16'($urandom), 1'b0);
         else if (r < 98) cyc(t, 1'b1, 1'b0, {1'b1, a[1:0]}, (r == 97) ? 16'($urandom) : d, 1'b0);
         else if (r == 98) cyc(t, 1'b1, 1'b1, a, d, 1'b0);
         else reset_for(int'($urandom_range(1, 2)));
      end
      cin_en[0] = 1'b0; cin_en[1] = 1'b0;
      reset_for(1);
      wr(3'b000, 16'h0000); wr(3'b100, 16'hFFFF);
      idle(65533);
      rd(3'b100); rd(3'b000);
      idle(1);
      rd(3'b100); rd(3'b000); rd(3'b000);
      idle(3);
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
